// File: rtl/mouse_ps2_pkg.sv
// -----------------------------------------------------------------------------
// mouse_ps2_pkg
// Shared definitions for the PS/2 mouse host-to-device command path:
//   - ps2_state_e       : command sender FSM state encoding
//   - CMD_*             : common mouse command bytes
//   - PS2_FRAME_BITS    : number of device clock falling edges in one
//                         host-to-device frame (8 data + parity + stop + ack)
//   - odd_parity()      : parity bit that makes data+parity an odd count of 1s
// -----------------------------------------------------------------------------
package mouse_ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_SEND      = 3'd2,
    ST_ACK       = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } ps2_state_e;

  localparam logic [7:0] CMD_RESET         = 8'hFF;
  localparam logic [7:0] CMD_ENABLE_REPORT = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE      = 8'hF3;

  localparam int unsigned PS2_FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
// Brings the raw PS/2 clock and data line levels into the clk domain and
// detects falling edges of the synchronized PS/2 clock.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset (lines treated as idle-high)
//   ps2_clk_i    raw PS/2 clock line level
//   ps2_data_i   raw PS/2 data line level
//   clk_sync_o   synchronized PS/2 clock level
//   data_sync_o  synchronized PS/2 data level
//   clk_fall_o   one-cycle strobe on a synchronized 1->0 clock transition
// -----------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic clk_fall_o
);

  logic clk_meta_q;
  logic clk_sync_q;
  logic clk_prev_q;
  logic data_meta_q;
  logic data_sync_q;

  // Two-flop synchronizers plus a delayed copy of the synchronized clock.
  // Reset to 1 so an idle bus never produces a spurious edge after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign clk_sync_o  = clk_sync_q;
  assign data_sync_o = data_sync_q;
  assign clk_fall_o  = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/mouse_cmd_sender.sv
// -----------------------------------------------------------------------------
// mouse_cmd_sender
// Sends one command byte from the host to a PS/2 mouse: inhibits the bus,
// requests to send, shifts out data/parity/stop on the device's clock, then
// samples the device acknowledge.
// Parameters:
//   INHIBIT_CYCLES  clk cycles the PS/2 clock is held low before the request
//   TIMEOUT_CYCLES  max clk cycles allowed between device clock falling edges
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   cmd_valid/cmd_data       command byte offer
//   cmd_ready                high only while idle; accept = valid & ready
//   ps2_clk_in/ps2_data_in   raw PS/2 line levels
//   ps2_clk_oe/ps2_data_oe   1 = pull the line low, 0 = release
//   busy                     high whenever a transfer is in progress
//   done                     one-cycle pulse when a transfer ends
//   ack_ok                   valid with done: 1 = device acknowledged
//   err                      one-cycle pulse with done on NACK or timeout
// -----------------------------------------------------------------------------
module mouse_cmd_sender
  import mouse_ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // bit_cnt_q holds the number of falling edges already seen in SEND, so the
  // edge being handled is bit_cnt_q + 1.
  localparam logic [3:0] DATA_EDGES = 4'd8;
  localparam logic [3:0] PARITY_IDX = 4'(PS2_FRAME_BITS - 3);
  localparam logic [3:0] STOP_IDX   = 4'(PS2_FRAME_BITS - 2);

  ps2_state_e       state_q,   state_d;
  logic [7:0]       byte_q,    byte_d;
  logic             parity_q,  parity_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic             clk_oe_q,  clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ack_q,     ack_d;
  logic             done_q,    done_d;
  logic             ack_ok_q,  ack_ok_d;
  logic             err_q,     err_d;
  logic             ready_q,   ready_d;
  logic             busy_q,    busy_d;

  logic clk_sync_s;
  logic data_sync_s;
  logic clk_fall_s;
  logic timeout_s;
  logic watched_s;

  ps2_line_sync u_line_sync (
    .clk_i       (clk),
    .rst_i       (rst),
    .ps2_clk_i   (ps2_clk_in),
    .ps2_data_i  (ps2_data_in),
    .clk_sync_o  (clk_sync_s),
    .data_sync_o (data_sync_s),
    .clk_fall_o  (clk_fall_s)
  );

  // A falling edge in the same cycle restarts the window, so it beats the timeout.
  assign timeout_s = (cyc_cnt_q == TIMEOUT_LAST) && !clk_fall_s;
  assign watched_s = (state_q == ST_SEND) || (state_q == ST_ACK) ||
                     (state_q == ST_WAIT_IDLE);

  // Next-state, line-drive and completion decode.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    ack_ok_d  = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        bit_cnt_d = 4'd0;
        ack_d     = 1'b0;
        if (cmd_valid) begin
          byte_d   = cmd_data;
          parity_d = odd_parity(cmd_data);
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_INHIBIT: begin
        // Clock release and start bit switch in the same register update,
        // so both drivers are never seen active together.
        if (cyc_cnt_q == INHIBIT_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = ST_SEND;
        end else begin
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
        end
      end

      ST_SEND: begin
        if (clk_fall_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < DATA_EDGES) begin
            data_oe_d = ~byte_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == PARITY_IDX) begin
            data_oe_d = ~parity_q;
          end else begin
            // Stop bit: release data and wait for the acknowledge edge.
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_ACK: begin
        if (clk_fall_s) begin
          ack_d   = ~data_sync_s;
          state_d = ST_WAIT_IDLE;
        end else begin
          ack_d   = ack_q;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_sync_s && data_sync_s) begin
          done_d   = 1'b1;
          ack_ok_d = ack_q;
          err_d    = ~ack_q;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_WAIT_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Device went silent: abandon the transfer and report failure.
    if (timeout_s && watched_s) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      ack_ok_d  = 1'b0;
      err_d     = 1'b1;
      state_d   = ST_IDLE;
    end else begin
      err_d     = err_d;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // Cycle counter: restarts on every state change and on every device clock
  // edge that the current state listens to; our own inhibit pulls the clock
  // low, so edges during INHIBIT must not stretch the inhibit time.
  always_comb begin
    if (state_d != state_q) begin
      cyc_cnt_d = {CNT_W{1'b0}};
    end else if (state_q == ST_IDLE) begin
      cyc_cnt_d = {CNT_W{1'b0}};
    end else if (clk_fall_s && (state_q != ST_INHIBIT)) begin
      cyc_cnt_d = {CNT_W{1'b0}};
    end else begin
      cyc_cnt_d = cyc_cnt_q + CNT_ONE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      byte_q    <= 8'h00;
      parity_q  <= 1'b0;
      bit_cnt_q <= 4'd0;
      cyc_cnt_q <= {CNT_W{1'b0}};
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      ack_ok_q  <= ack_ok_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mouse_cmd_sender.sv
// -----------------------------------------------------------------------------
// tb_mouse_cmd_sender
// Drives mouse_cmd_sender against a behavioural PS/2 device that clocks the
// frame, records the bits it receives and answers ACK or NACK. Received
// frames are compared with a frame built directly from the byte.
// -----------------------------------------------------------------------------
module tb_mouse_cmd_sender;
  import mouse_ps2_pkg::*;

  localparam int unsigned INH  = 300;
  localparam int unsigned TMO  = 1500;
  localparam int          HALF = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2_clk_in;
  logic       ps2_data_in;

  // Open-drain bus: either side may pull a line low.
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  mouse_cmd_sender #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .err         (err)
  );

  int total = 0;
  int bad   = 0;

  // Continuous observations, sampled on the falling clk edge.
  int done_cnt       = 0;
  int overlap        = 0;
  int stray_err      = 0;
  int busy_mismatch  = 0;
  int ready_in_frame = 0;
  int oe_active      = 0;
  bit in_frame       = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1 && done !== 1'b1) stray_err++;
    if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) overlap++;
    if (busy !== ~cmd_ready) busy_mismatch++;
    if (in_frame && cmd_ready === 1'b1 && done !== 1'b1) ready_in_frame++;
    if (ps2_clk_oe === 1'b1 || ps2_data_oe === 1'b1) oe_active++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Frame as the device should see it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // One host-to-device transfer with the device model.
  // stop_after: device edge at which clocking stops (11 = full frame).
  // do_rst: instead of timing out at stop_after, pulse rst there.
  // hold: keep cmd_valid high through done (expect a back-to-back start).
  task automatic xfer(input logic [7:0] cmd, input bit nack, input int stop_after,
                      input bit do_rst, input bit hold, input bit exp_ack,
                      input bit exp_err, input string tag, output logic [10:0] rx);
    int n;
    int inh;
    int d0;
    int r0;
    int rel;
    bit stopped;
    rx      = 11'h000;
    stopped = 1'b0;
    d0      = done_cnt;
    r0      = ready_in_frame;
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " accept"}, 32'(n < 20), 32'd1);
    in_frame = 1'b1;
    if (!hold) cmd_valid = 1'b0;
    check({tag, " inhibit data released"}, 32'(ps2_data_oe), 32'd0);
    inh = 0;
    while (ps2_clk_oe === 1'b1 && inh < int'(INH) + 20) begin
      inh++;
      tick();
    end
    check({tag, " inhibit length"}, 32'(inh), 32'(INH));
    check({tag, " start bit driven"}, 32'(ps2_data_oe), 32'd1);
    check({tag, " busy in frame"}, 32'(busy), 32'd1);

    repeat (4) tick();
    rx[0] = ps2_data_in;
    for (int e = 1; e <= 10; e++) begin
      if (!stopped) begin
        repeat (HALF) tick();
        dev_clk = 1'b0;
        if (e == stop_after && !do_rst) begin
          // Device goes silent with the clock low: measure the timeout.
          stopped = 1'b1;
          n = 0;
          while (done !== 1'b1 && n < int'(TMO) + 50) begin
            tick();
            n++;
          end
          check({tag, " timeout latency"}, 32'(n), 32'(TMO + 3));
          check({tag, " timeout clk_oe"}, 32'(ps2_clk_oe), 32'd0);
          check({tag, " timeout data_oe"}, 32'(ps2_data_oe), 32'd0);
          check({tag, " timeout err"}, 32'(err), 32'd1);
          check({tag, " timeout ack_ok"}, 32'(ack_ok), 32'd0);
          tick();
          in_frame = 1'b0;
          check({tag, " timeout done width"}, 32'(done), 32'd0);
          check({tag, " timeout back to idle"}, 32'(cmd_ready), 32'd1);
          dev_clk = 1'b1;
        end else if (e == stop_after && do_rst) begin
          stopped = 1'b1;
          repeat (4) tick();
          check({tag, " bit driven before reset"}, 32'(ps2_data_oe), 32'd1);
          in_frame = 1'b0;
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check({tag, " reset clk_oe"}, 32'(ps2_clk_oe), 32'd0);
          check({tag, " reset data_oe"}, 32'(ps2_data_oe), 32'd0);
          check({tag, " reset cmd_ready"}, 32'(cmd_ready), 32'd1);
          check({tag, " reset busy"}, 32'(busy), 32'd0);
          dev_clk = 1'b1;
          repeat (30) tick();
          check({tag, " reset no done"}, 32'(done_cnt), 32'(d0));
          check({tag, " reset stays idle"}, 32'(ps2_clk_oe), 32'd0);
        end else begin
          if (!hold && e == 3) begin
            // A command offered mid-frame must be ignored entirely.
            cmd_data  = ~cmd;
            cmd_valid = 1'b1;
          end
          repeat (HALF) tick();
          if (!hold && e == 3) cmd_valid = 1'b0;
          dev_clk = 1'b1;
          rx[e]   = ps2_data_in;
        end
      end
    end

    if (!stopped) begin
      repeat (HALF) tick();
      dev_data = nack ? 1'b1 : 1'b0;
      repeat (HALF) tick();
      dev_clk = 1'b0;
      repeat (HALF) tick();
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check({tag, " done seen"}, 32'(n < 40), 32'd1);
      check({tag, " single done"}, 32'(done_cnt), 32'(d0 + 1));
      check({tag, " ack_ok"}, 32'(ack_ok), 32'(exp_ack));
      check({tag, " err"}, 32'(err), 32'(exp_err));
      check({tag, " ready low in frame"}, 32'(ready_in_frame), 32'(r0));
      tick();
      in_frame = 1'b0;
      check({tag, " done width"}, 32'(done), 32'd0);
      if (hold) begin
        check({tag, " back-to-back start"}, 32'(ps2_clk_oe), 32'd1);
      end else begin
        check({tag, " idle after done"}, 32'(cmd_ready), 32'd1);
        rel = 0;
        repeat (5) begin
          tick();
          if (ps2_clk_oe !== 1'b0) rel++;
        end
        check({tag, " no queued command"}, 32'(rel), 32'd0);
      end
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    bit         nack;
    bit         par;
    bit         ack;
    bit         err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [10:0] rx;
    logic [7:0]  b;
    bit          nk;
    int          oe0;

    vecs[0] = '{CMD_ENABLE_REPORT, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{CMD_RESET,         1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{CMD_SET_RATE,      1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h00,             1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h01,             1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hAA,             1'b0, 1'b1, 1'b1, 1'b0};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    dev_clk   = 1'b1;
    dev_data  = 1'b1;
    repeat (3) tick();
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("reset data_oe", 32'(ps2_data_oe), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ack_ok", 32'(ack_ok), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Device-initiated clocking while idle must be ignored.
    oe0 = oe_active;
    for (int i = 0; i < 11; i++) begin
      repeat (HALF) tick();
      dev_clk = 1'b0;
      repeat (HALF) tick();
      dev_clk = 1'b1;
    end
    repeat (5) tick();
    check("idle traffic no drive", 32'(oe_active), 32'(oe0));
    check("idle traffic no done", 32'(done_cnt), 32'd0);
    check("idle traffic ready", 32'(cmd_ready), 32'd1);

    // Table-driven full transfers.
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].cmd, vecs[i].nack, 11, 1'b0, 1'b0, vecs[i].ack, vecs[i].err, "vec", rx);
      check("vec frame", 32'(rx), 32'(frame_of(vecs[i].cmd)));
      check("vec parity bit", 32'(rx[9]), 32'(vecs[i].par));
    end

    // Randomized bytes and device responses against the frame model.
    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom_range(0, 255));
      nk = 1'($urandom_range(0, 1));
      xfer(b, nk, 11, 1'b0, 1'b0, ~nk, nk, "rand", rx);
      check("rand frame", 32'(rx), 32'(frame_of(b)));
    end

    // cmd_valid held through two back-to-back transfers.
    xfer(CMD_SET_RATE, 1'b0, 11, 1'b0, 1'b1, 1'b1, 1'b0, "hold1", rx);
    check("hold1 frame", 32'(rx), 32'(frame_of(CMD_SET_RATE)));
    xfer(CMD_SET_RATE, 1'b0, 11, 1'b0, 1'b0, 1'b1, 1'b0, "hold2", rx);
    check("hold2 frame", 32'(rx), 32'(frame_of(CMD_SET_RATE)));

    // Device stops clocking after edge 4.
    xfer(CMD_ENABLE_REPORT, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1, "tmo", rx);

    // Reset at bit 5 of SEND.
    xfer(8'h00, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0, "rst", rx);

    // A normal transfer still works after the abort paths.
    xfer(CMD_ENABLE_REPORT, 1'b0, 11, 1'b0, 1'b0, 1'b1, 1'b0, "after", rx);
    check("after frame", 32'(rx), 32'(frame_of(CMD_ENABLE_REPORT)));

    check("oe never both high", 32'(overlap), 32'd0);
    check("err only with done", 32'(stray_err), 32'd0);
    check("busy is not ready", 32'(busy_mismatch), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mouse_cmd_sender.md
MOUSE_CMD_SENDER -- requirements
Module: mouse_cmd_sender

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, host clock-inhibit duration in clk cycles (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, maximum clk cycles allowed between device clock falling edges (20 ms).
REQ-003 clk  input  1  system clock; the block uses this single clock only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command byte offered.
REQ-006 cmd_data  input  8  command byte (e.g. 0xF4, 0xFF).
REQ-007 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-008 ps2_clk_in  input  1  raw PS/2 clock line level.
REQ-009 ps2_data_in  input  1  raw PS/2 data line level.
REQ-010 ps2_clk_oe  output  1  1 = drive PS/2 clock low; 0 = release the line.
REQ-011 ps2_data_oe  output  1  1 = drive PS/2 data low; 0 = release the line.
REQ-012 busy  output  1  high in every state except IDLE; the packet receiver ignores bytes while busy is high.
REQ-013 done  output  1  one-cycle pulse when a transfer ends, whether it succeeds or fails.
REQ-014 ack_ok  output  1  valid when done is high; 1 = device ACK received (data sampled low at edge 11).
REQ-015 err  output  1  one-cycle pulse, coincident with done, on timeout or NACK.

Function
REQ-016 ps2_clk_in and ps2_data_in SHALL pass through two-flop synchronizers; a falling edge is a synchronized 1->0 transition of the clock.
REQ-017 States: IDLE, INHIBIT, SEND, ACK, WAIT_IDLE.
REQ-018 On accept, latch cmd_data and the odd parity bit (~^cmd_data), then enter INHIBIT on the next cycle.
REQ-019 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles; then enter SEND with ps2_clk_oe=0 and ps2_data_oe=1 (start bit).
REQ-020 SEND: a bit counter starts at 0 and increments on each falling edge.
REQ-021 SEND falling edges 1-8 place data bits LSB first, with ps2_data_oe = ~bit.
REQ-022 SEND falling edge 9 places the parity bit; edge 10 sets ps2_data_oe=0 (stop bit); then enter ACK.
REQ-023 ACK: on the next falling edge, sample synchronized data; 0 -> ack_ok=1, 1 -> ack_ok=0 and err pulse; then enter WAIT_IDLE.
REQ-024 WAIT_IDLE: once both synchronized lines are high, pulse done for one cycle and return to IDLE.
REQ-025 Timeout: a cycle counter clears on every falling edge and on every state entry; if it reaches TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE, release both lines and pulse done=1, ack_ok=0, err=1 in the same cycle, then go to IDLE.
REQ-026 Both oe outputs SHALL be registered, glitch-free, and never both 1 except during the single INHIBIT->SEND transition cycle.
REQ-027 cmd_valid asserted outside IDLE is ignored: it is not queued and has no effect.
REQ-028 cmd_valid held high through done starts a new transfer one cycle after the return to IDLE.
REQ-029 Falling edges seen in IDLE or INHIBIT (device-initiated traffic) SHALL be ignored.

Reset
REQ-030 rst wins over all other inputs; next state is IDLE with ps2_clk_oe=0, ps2_data_oe=0, done=0, ack_ok=0, err=0, busy=0, cmd_ready=1, and all counters at 0.
REQ-031 rst asserted mid-transfer releases both lines on the next clk edge; no done pulse is produced.

Structure
REQ-032 Shared package mouse_ps2_pkg SHALL hold: the state encoding; command constants CMD_RESET=0xFF, CMD_ENABLE_REPORT=0xF4, CMD_SET_RATE=0xF3; and the PS/2 frame length (11).
REQ-033 One sub-module, ps2_line_sync, SHALL hold the two-flop synchronizers and the falling-edge detector; the FSM and counters stay in mouse_cmd_sender.

Verification
REQ-034 Send 0xF4 with a device model that ACKs -> data_oe pattern start 1; bits 0,0,1,0,1,1,1,1 give oe 1,1,0,1,0,0,0,0; parity 0 gives oe 1; stop gives oe 0; result done=1, ack_ok=1, err=0.
REQ-035 Send 0xFF -> parity bit 1 (oe 0 at edge 9); clk_oe stays high for exactly 10000 cycles before release.
REQ-036 Device model NACKs (data high at edge 11) -> done=1, ack_ok=0, err=1 in one cycle, then IDLE.
REQ-037 Device stops clocking after edge 4 -> after exactly 2000000 cycles both oe=0 and done=err=1.
REQ-038 rst pulsed at bit 5 of SEND -> both oe=0 on the next cycle, no done pulse, cmd_ready=1.
REQ-039 cmd_valid held through two transfers of 0xF3 -> two complete frames, with cmd_ready low throughout each frame.
